// File: rtl/preg_freelist_alloc_if.sv
// Free-list bus between rename (master) and the free-list controller (slave).
//  alloc_req/alloc_ready/alloc_preg : show-ahead allocation handshake
//  commit_valid/commit_old_prd      : release of a committing instr's old_prd
//  flush_valid                      : drop all speculative allocations
//  free_count                       : speculative free entries
interface preg_freelist_alloc_if #(
  parameter int PREG_W = 6,
  parameter int PTR_W  = 5
);
  logic              alloc_req;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_preg;
  logic              commit_valid;
  logic [PREG_W-1:0] commit_old_prd;
  logic              flush_valid;
  logic [PTR_W:0]    free_count;

  modport master (
    output alloc_req, commit_valid, commit_old_prd, flush_valid,
    input  alloc_ready, alloc_preg, free_count
  );

  modport slave (
    input  alloc_req, commit_valid, commit_old_prd, flush_valid,
    output alloc_ready, alloc_preg, free_count
  );
endinterface

// File: rtl/preg_freelist_alloc.sv
// Physical-register free list feeding rename.
// Circular buffer of free preg indices with three pointers:
//  spec_head   - next entry handed to rename (speculative)
//  commit_head - spec_head as seen by committed instrs; flush restores to it
//  tail        - where committing instrs release their old_prd
// Ports:
//  clock, reset : clock and synchronous active-high reset
//  bus (slave)  : alloc handshake, commit release, flush, free_count
module preg_freelist_alloc #(
  parameter int PREG_NUM = 64,
  parameter int LREG_NUM = 32,
  parameter int PREG_W   = $clog2(PREG_NUM),
  parameter int DEPTH    = PREG_NUM - LREG_NUM,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input logic                 clock,
  input logic                 reset,
  preg_freelist_alloc_if.slave bus
);
  localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

  logic [PREG_W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]    spec_head, commit_head, tail;
  logic              alloc_fire;

  assign bus.alloc_ready = (tail != spec_head);
  assign bus.alloc_preg  = mem[spec_head[PTR_W-1:0]];
  assign bus.free_count  = tail - spec_head;
  // A flush cancels any allocation requested in the same cycle.
  assign alloc_fire      = bus.alloc_req & bus.alloc_ready & ~bus.flush_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PREG_W'(LREG_NUM + i);
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= DEPTH_P;
    end else begin
      if (bus.commit_valid) begin
        mem[tail[PTR_W-1:0]] <= bus.commit_old_prd;
        tail                 <= tail + 1'b1;
        commit_head          <= commit_head + 1'b1;
      end
      // Flush restores the committed head including this cycle's commit.
      if (bus.flush_valid)
        spec_head <= bus.commit_valid ? commit_head + 1'b1 : commit_head;
      else if (alloc_fire)
        spec_head <= spec_head + 1'b1;
    end
  end

  // Released entries can never exceed the list capacity.
  a_no_over_release: assert property (@(posedge clock) disable iff (reset)
    (PTR_W+1)'(tail - commit_head) <= DEPTH_P);
  // Commit may only retire entries that were actually allocated.
  a_commit_behind_spec: assert property (@(posedge clock) disable iff (reset)
    (PTR_W+1)'(spec_head - commit_head) <= DEPTH_P);
endmodule

// File: tb/tb_preg_freelist_alloc.sv
module tb_preg_freelist_alloc;
  localparam int PREG_NUM = 64, LREG_NUM = 32, PREG_W = 6, DEPTH = 32, PTR_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  preg_freelist_alloc_if #(.PREG_W(PREG_W), .PTR_W(PTR_W)) bus();

  preg_freelist_alloc #(
    .PREG_NUM(PREG_NUM), .LREG_NUM(LREG_NUM), .PREG_W(PREG_W),
    .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic idle();
    bus.alloc_req      = 1'b0;
    bus.commit_valid   = 1'b0;
    bus.commit_old_prd = '0;
    bus.flush_valid    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock with the given inputs; returns at the following negedge.
  task automatic cycle(input logic req, input logic cv, input logic [PREG_W-1:0] old,
                       input logic fl);
    bus.alloc_req      = req;
    bus.commit_valid   = cv;
    bus.commit_old_prd = old;
    bus.flush_valid    = fl;
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0d want 1", bus.alloc_ready); end
    n_checks++;
    if (bus.alloc_preg !== 6'd32) begin n_fail++; $display("FAIL reset_preg got %0d want 32", bus.alloc_preg); end
    n_checks++;
    if (bus.free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count got %0d want 32", bus.free_count); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (bus.alloc_ready !== 1'b1 || bus.alloc_preg !== PREG_W'(LREG_NUM + i)) begin
        n_fail++;
        $display("FAIL drain_preg[%0d] got rdy=%0d preg=%0d want rdy=1 preg=%0d", i, bus.alloc_ready, bus.alloc_preg, LREG_NUM + i);
      end
      cycle(1'b1, 1'b0, '0, 1'b0);
    end
    n_checks++;
    if (bus.alloc_ready !== 1'b0 || bus.free_count !== 6'd0) begin
      n_fail++; $display("FAIL drain_empty got rdy=%0d cnt=%0d want rdy=0 cnt=0", bus.alloc_ready, bus.free_count);
    end
    cycle(1'b1, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus.alloc_ready !== 1'b0 || bus.free_count !== 6'd0) begin
      n_fail++; $display("FAIL drain_no_fire got rdy=%0d cnt=%0d want rdy=0 cnt=0", bus.alloc_ready, bus.free_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus.alloc_preg !== 6'd35 || bus.free_count !== 6'd29) begin
      n_fail++; $display("FAIL flush_pre got preg=%0d cnt=%0d want preg=35 cnt=29", bus.alloc_preg, bus.free_count);
    end
    // alloc_req alongside flush must not allocate
    cycle(1'b1, 1'b0, '0, 1'b1);
    n_checks++;
    if (bus.alloc_preg !== 6'd32 || bus.free_count !== 6'd32) begin
      n_fail++; $display("FAIL flush_restore got preg=%0d cnt=%0d want preg=32 cnt=32", bus.alloc_preg, bus.free_count);
    end
  endtask

  task automatic test_commit_flush();
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 6'd5, 1'b1);
    n_checks++;
    if (bus.alloc_preg !== 6'd33 || bus.free_count !== 6'd32) begin
      n_fail++; $display("FAIL commit_flush got preg=%0d cnt=%0d want preg=33 cnt=32", bus.alloc_preg, bus.free_count);
    end
    for (int i = 0; i < 31; i++) begin
      n_checks++;
      if (bus.alloc_preg !== PREG_W'(33 + i)) begin
        n_fail++; $display("FAIL commit_flush_seq[%0d] got %0d want %0d", i, bus.alloc_preg, 33 + i);
      end
      cycle(1'b1, 1'b0, '0, 1'b0);
    end
    n_checks++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_preg !== 6'd5 || bus.free_count !== 6'd1) begin
      n_fail++; $display("FAIL commit_flush_wrap got rdy=%0d preg=%0d cnt=%0d want rdy=1 preg=5 cnt=1", bus.alloc_ready, bus.alloc_preg, bus.free_count);
    end
  endtask

  task automatic test_release_empty();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    bus.commit_valid   = 1'b1;
    bus.commit_old_prd = 6'd7;
    bus.alloc_req      = 1'b1;
    #1;
    n_checks++;
    if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL release_no_bypass got rdy=%0d want 0", bus.alloc_ready); end
    @(posedge clock);
    @(negedge clock);
    idle();
    n_checks++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_preg !== 6'd7 || bus.free_count !== 6'd1) begin
      n_fail++; $display("FAIL release_next got rdy=%0d preg=%0d cnt=%0d want rdy=1 preg=7 cnt=1", bus.alloc_ready, bus.alloc_preg, bus.free_count);
    end
  endtask

  // Reference: a rename map + in-order ROB. The free list is the ordered
  // sequence of free pregs from the committed head; spec allocations are the
  // first rob.size() of them.
  typedef struct { int lreg; int newp; int oldp; } rob_t;

  task automatic test_random();
    rob_t rob[$];
    int   flist[$];
    int   cmap[LREG_NUM];
    int   smap[LREG_NUM];
    int   allocs = 0;
    int   exp_cnt, newp;
    bit   req, cv, fl, fire, live;
    rob_t e;
    do_reset();
    for (int i = 0; i < LREG_NUM; i++) begin cmap[i] = i; smap[i] = i; end
    for (int i = 0; i < DEPTH; i++) flist.push_back(LREG_NUM + i);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      exp_cnt = flist.size() - rob.size();
      n_checks++;
      if (bus.free_count !== PTR_W'(0) + (PTR_W+1)'(exp_cnt) || bus.alloc_ready !== (exp_cnt != 0)) begin
        n_fail++; $display("FAIL rand_count cyc=%0d got cnt=%0d rdy=%0d want cnt=%0d", cyc, bus.free_count, bus.alloc_ready, exp_cnt);
      end
      newp = (exp_cnt != 0) ? flist[rob.size()] : -1;
      if (exp_cnt != 0) begin
        n_checks++;
        if (bus.alloc_preg !== PREG_W'(newp)) begin
          n_fail++; $display("FAIL rand_preg cyc=%0d got %0d want %0d", cyc, bus.alloc_preg, newp);
        end
      end
      req  = ($urandom_range(0, 99) < 55);
      cv   = (rob.size() > 0) && ($urandom_range(0, 99) < 45);
      fl   = ($urandom_range(0, 99) < 4);
      fire = req && (exp_cnt != 0) && !fl;
      cycle(req, cv, cv ? PREG_W'(rob[0].oldp) : '0, fl);
      if (cv) begin
        e = rob.pop_front();
        cmap[e.lreg] = e.newp;
        void'(flist.pop_front());
        flist.push_back(e.oldp);
      end
      if (fire) begin
        live = 1'b0;
        foreach (cmap[k]) if (cmap[k] == newp) live = 1'b1;
        foreach (rob[k]) if (rob[k].newp == newp) live = 1'b1;
        n_checks++;
        if (live) begin n_fail++; $display("FAIL rand_live cyc=%0d preg %0d handed out while live", cyc, newp); end
        e.lreg = $urandom_range(0, LREG_NUM - 1);
        e.newp = newp;
        e.oldp = smap[e.lreg];
        smap[e.lreg] = newp;
        rob.push_back(e);
        allocs++;
      end
      if (fl) begin
        rob.delete();
        smap = cmap;
      end
    end
    $display("random phase: %0d allocations", allocs);
  endtask

  initial begin
    idle();
    test_reset();
    test_drain();
    test_flush();
    test_commit_flush();
    test_release_empty();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
